// File: rtl/pcie_txs_pkg.sv
// Shared constants, FSM state and read-tracker entry type for the TXS arbiter.
package pcie_txs_pkg;

  localparam int unsigned TXS_ADDR_W  = 64;
  localparam int unsigned TXS_DATA_W  = 128;
  localparam int unsigned TXS_BE_W    = 16;
  localparam int unsigned TXS_BURST_W = 6;
  // Wide enough for up to 8 requesters.
  localparam int unsigned TXS_ID_W    = 3;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } txs_state_e;

  typedef struct packed {
    logic [TXS_ID_W-1:0]    id;
    logic [TXS_BURST_W-1:0] burstcount;
  } rd_entry_t;

  // A burstcount of zero is treated as a single beat.
  function automatic logic [TXS_BURST_W-1:0] norm_burst(input logic [TXS_BURST_W-1:0] bc);
    return (bc == '0) ? TXS_BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/pcie_txs_rd_tracker.sv
// In-order outstanding-read tracker: FIFO of {id, burstcount}, response beat
// counter, full/empty flags and sticky error for orphan read data.
module pcie_txs_rd_tracker
  import pcie_txs_pkg::*;
#(
  parameter int unsigned RD_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  rd_entry_t           push_entry_i,
  input  logic                rdv_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [TXS_ID_W-1:0] head_id_o,
  output logic                beat_valid_o,
  output logic                err_o
);

  localparam int unsigned PTR_W = $clog2(RD_DEPTH);

  rd_entry_t              mem_q [RD_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
  logic [TXS_BURST_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic                   err_q, err_d;
  rd_entry_t              head;

  assign head         = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign empty_o      = (wr_ptr_q == rd_ptr_q);
  assign full_o       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_id_o    = head.id;
  assign beat_valid_o = rdv_i && !empty_o;
  assign err_o        = err_q;

  // Pointer advance, response beat counting and head pop on last beat.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rsp_cnt_d = rsp_cnt_q;
    err_d     = err_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (rdv_i) begin
      if (empty_o) begin
        err_d = 1'b1;
      end else if (rsp_cnt_q == head.burstcount - TXS_BURST_W'(1)) begin
        rsp_cnt_d = '0;
        rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
      end else begin
        rsp_cnt_d = rsp_cnt_q + TXS_BURST_W'(1);
      end
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rsp_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rsp_cnt_q <= rsp_cnt_d;
      err_q     <= err_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_i;
    end
  end

endmodule

// File: rtl/pcie_txs_arbiter.sv
// Round-robin, burst-granular arbiter sharing the hard IP TXS slave port
// among NUM_REQ masters, with in-order read-response routing.
module pcie_txs_arbiter
  import pcie_txs_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned RD_DEPTH = 8
) (
  input  logic                   coreclkout_hip,
  input  logic                   app_nreset_status,
  input  logic [64*NUM_REQ-1:0]  req_address_i,
  input  logic [16*NUM_REQ-1:0]  req_byteenable_i,
  input  logic [128*NUM_REQ-1:0] req_writedata_i,
  input  logic [NUM_REQ-1:0]     req_read_i,
  input  logic [NUM_REQ-1:0]     req_write_i,
  input  logic [6*NUM_REQ-1:0]   req_burstcount_i,
  output logic [NUM_REQ-1:0]     req_waitrequest_o,
  output logic [127:0]           req_readdata_o,
  output logic [NUM_REQ-1:0]     req_readdatavalid_o,
  output logic [63:0]            txs_address_i,
  output logic [15:0]            txs_byteenable_i,
  output logic [127:0]           txs_writedata_i,
  output logic                   txs_read_i,
  output logic                   txs_write_i,
  output logic [5:0]             txs_burstcount_i,
  output logic                   txs_chipselect_i,
  input  logic [127:0]           txs_readdata_o,
  input  logic                   txs_readdatavalid_o,
  input  logic                   txs_waitrequest_o,
  output logic                   err_o
);

  txs_state_e             state_q, state_d;
  logic [TXS_ID_W-1:0]    grant_q, grant_d;
  logic [TXS_BURST_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TXS_BURST_W-1:0] burst_q, burst_d;
  logic [TXS_BURST_W-1:0] eff_burst;

  logic                   cmd_rd, cmd_wr;
  logic [TXS_BURST_W-1:0] cmd_bc;
  logic [NUM_REQ-1:0]     elig;
  logic                   found;
  logic [TXS_ID_W-1:0]    pick;
  logic                   xfer;
  logic                   push;
  rd_entry_t              push_entry;
  logic                   trk_full, trk_empty, trk_beat;
  logic [TXS_ID_W-1:0]    trk_head_id;

  assign xfer = (state_q == ST_XFER);

  // Mux the granted requester's command onto the TXS port.
  always_comb begin
    cmd_rd           = 1'b0;
    cmd_wr           = 1'b0;
    cmd_bc           = '0;
    txs_address_i    = '0;
    txs_byteenable_i = '0;
    txs_writedata_i  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == TXS_ID_W'(i)) begin
        cmd_rd           = req_read_i[i];
        cmd_wr           = req_write_i[i];
        cmd_bc           = req_burstcount_i[6*i +: 6];
        txs_address_i    = req_address_i[64*i +: 64];
        txs_byteenable_i = req_byteenable_i[16*i +: 16];
        txs_writedata_i  = req_writedata_i[128*i +: 128];
      end
    end
  end

  assign txs_write_i      = xfer && cmd_wr;
  assign txs_read_i       = xfer && cmd_rd && !cmd_wr;
  assign txs_chipselect_i = txs_read_i || txs_write_i;
  assign txs_burstcount_i = cmd_bc;
  assign req_readdata_o   = txs_readdata_o;

  // Per-requester stall and one-hot read-data routing from the tracker head.
  always_comb begin
    req_waitrequest_o   = '1;
    req_readdatavalid_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i]                = req_write_i[i] || (req_read_i[i] && !trk_full);
      req_waitrequest_o[i]   = !(xfer && (grant_q == TXS_ID_W'(i)) && !txs_waitrequest_o);
      req_readdatavalid_o[i] = trk_beat && (trk_head_id == TXS_ID_W'(i));
    end
  end

  // Round-robin pick: scan starting one past the last grantee.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = grant_q;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(grant_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && elig[j]) begin
          found = 1'b1;
          pick  = TXS_ID_W'(j);
        end
      end
    end
  end

  // Arbitration / transfer FSM next state. A grant that sees neither strobe
  // before its first beat is released so a withdrawn request cannot hang it.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    burst_d    = burst_q;
    push       = 1'b0;
    push_entry = '{id: grant_q, burstcount: norm_burst(cmd_bc)};
    eff_burst  = (beat_cnt_q == '0) ? norm_burst(cmd_bc) : burst_q;
    unique case (state_q)
      ST_ARB: begin
        if (found) begin
          state_d    = ST_XFER;
          grant_d    = pick;
          beat_cnt_d = '0;
        end
      end
      ST_XFER: begin
        if (cmd_wr) begin
          if (!txs_waitrequest_o) begin
            if (beat_cnt_q == '0) begin
              burst_d = norm_burst(cmd_bc);
            end
            if (beat_cnt_q == eff_burst - TXS_BURST_W'(1)) begin
              beat_cnt_d = '0;
              state_d    = ST_ARB;
            end else begin
              beat_cnt_d = beat_cnt_q + TXS_BURST_W'(1);
            end
          end
        end else if (cmd_rd) begin
          if (!txs_waitrequest_o) begin
            push    = 1'b1;
            state_d = ST_ARB;
          end
        end else if (beat_cnt_q == '0) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // FSM and burst registers.
  always_ff @(posedge coreclkout_hip or negedge app_nreset_status) begin
    if (!app_nreset_status) begin
      state_q    <= ST_ARB;
      grant_q    <= TXS_ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      burst_q    <= burst_d;
    end
  end

  pcie_txs_rd_tracker #(
    .RD_DEPTH (RD_DEPTH)
  ) u_rd_tracker (
    .clk          (coreclkout_hip),
    .rst_n        (app_nreset_status),
    .push_i       (push),
    .push_entry_i (push_entry),
    .rdv_i        (txs_readdatavalid_o),
    .full_o       (trk_full),
    .empty_o      (trk_empty),
    .head_id_o    (trk_head_id),
    .beat_valid_o (trk_beat),
    .err_o        (err_o)
  );

endmodule

// File: tb/tb_pcie_txs_arbiter.sv
// Scoreboard bench for pcie_txs_arbiter: write beats and read-response routing
// are predicted when stimulus is issued and checked as the DUT produces them.
module tb_pcie_txs_arbiter;

  localparam int unsigned NR  = 2;
  localparam int unsigned RDD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0]  r_addr  [NR];
  logic [127:0] r_wdata [NR];
  logic         r_rd    [NR];
  logic         r_wr    [NR];
  logic [5:0]   r_bc    [NR];

  logic [64*NR-1:0]  req_address;
  logic [16*NR-1:0]  req_byteenable;
  logic [128*NR-1:0] req_writedata;
  logic [NR-1:0]     req_read, req_write;
  logic [6*NR-1:0]   req_burstcount;
  logic [NR-1:0]     req_waitrequest, req_readdatavalid;
  logic [127:0]      req_readdata;
  logic [63:0]       txs_address;
  logic [15:0]       txs_byteenable;
  logic [127:0]      txs_writedata;
  logic              txs_read, txs_write, txs_chipselect;
  logic [5:0]        txs_burstcount;
  logic [127:0]      txs_rdata;
  logic              txs_rdv, txs_wait;
  logic              err;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_address[64*i +: 64]     = r_addr[i];
      req_byteenable[16*i +: 16]  = '1;
      req_writedata[128*i +: 128] = r_wdata[i];
      req_read[i]                 = r_rd[i];
      req_write[i]                = r_wr[i];
      req_burstcount[6*i +: 6]    = r_bc[i];
    end
  end

  pcie_txs_arbiter #(
    .NUM_REQ  (NR),
    .RD_DEPTH (RDD)
  ) dut (
    .coreclkout_hip      (clk),
    .app_nreset_status   (rst_n),
    .req_address_i       (req_address),
    .req_byteenable_i    (req_byteenable),
    .req_writedata_i     (req_writedata),
    .req_read_i          (req_read),
    .req_write_i         (req_write),
    .req_burstcount_i    (req_burstcount),
    .req_waitrequest_o   (req_waitrequest),
    .req_readdata_o      (req_readdata),
    .req_readdatavalid_o (req_readdatavalid),
    .txs_address_i       (txs_address),
    .txs_byteenable_i    (txs_byteenable),
    .txs_writedata_i     (txs_writedata),
    .txs_read_i          (txs_read),
    .txs_write_i         (txs_write),
    .txs_burstcount_i    (txs_burstcount),
    .txs_chipselect_i    (txs_chipselect),
    .txs_readdata_o      (txs_rdata),
    .txs_readdatavalid_o (txs_rdv),
    .txs_waitrequest_o   (txs_wait),
    .err_o               (err)
  );

  typedef struct {
    logic [127:0] data;
    logic [63:0]  addr;
    logic [5:0]   bc;
  } wr_exp_t;

  wr_exp_t exp_wr [$];
  int      exp_rd [$];
  int      wr_cyc [$];
  int      n_checks = 0;
  int      n_pass   = 0;
  int      cyc      = 0;
  int      rd_acc   = 0;
  int      wr_beats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [127:0] pat(input int r, input logic [63:0] addr, input int k);
    return {addr, 32'(r) | 32'hC0DE_0000, 32'(k)};
  endfunction

  task automatic exp_write(input int r, input logic [63:0] addr, input int n, input logic [5:0] bc);
    for (int k = 0; k < n; k++) exp_wr.push_back('{pat(r, addr, k), addr, bc});
  endtask

  // Avalon master write burst; called at a negedge, returns at a negedge.
  task automatic wr_burst(input int r, input logic [63:0] addr, input int n, input logic [5:0] bc);
    int  k = 0;
    int  t = 0;
    logic acc;
    r_wr[r] = 1'b1; r_addr[r] = addr; r_bc[r] = bc; r_wdata[r] = pat(r, addr, 0);
    while (k < n && t < 1000) begin
      #2 acc = !req_waitrequest[r];
      @(negedge clk);
      t++;
      if (acc) begin
        k++;
        if (k < n) r_wdata[r] = pat(r, addr, k);
      end
    end
    r_wr[r] = 1'b0;
    chk($sformatf("wr_done_r%0d", r), 128'(k), 128'(n));
  endtask

  task automatic rd_burst(input int r, input logic [63:0] addr, input int n);
    int  t = 0;
    logic acc = 1'b0;
    r_rd[r] = 1'b1; r_addr[r] = addr; r_bc[r] = 6'(n);
    while (!acc && t < 1000) begin
      #2 acc = !req_waitrequest[r];
      @(negedge clk);
      t++;
    end
    r_rd[r] = 1'b0;
    chk($sformatf("rd_accept_r%0d", r), 128'(acc), 128'(1));
  endtask

  task automatic return_beats(input int n);
    for (int k = 0; k < n; k++) begin
      txs_rdv   = 1'b1;
      txs_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    txs_rdv = 1'b0;
  endtask

  // Monitor: samples mid-low-phase, after all negedge drives have settled.
  initial begin
    wr_exp_t e;
    int      r;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (txs_write && !txs_wait) begin
          wr_beats++;
          wr_cyc.push_back(cyc);
          if (exp_wr.size() == 0) chk("wr_unexpected", 128'(txs_write), 128'(0));
          else begin
            e = exp_wr.pop_front();
            chk("wr_data", txs_writedata, e.data);
            chk("wr_addr", 128'(txs_address), 128'(e.addr));
            chk("wr_bc", 128'(txs_burstcount), 128'(e.bc));
          end
        end
        if (txs_read && !txs_wait) rd_acc++;
        if (txs_rdv) begin
          if (exp_rd.size() == 0) chk("rdv_orphan", 128'(req_readdatavalid), 128'(0));
          else begin
            r = exp_rd.pop_front();
            chk("rdv_route", 128'(req_readdatavalid), 128'(1) << r);
            chk("rd_data", req_readdata, txs_rdata);
          end
        end
      end
    end
  end

  initial begin
    int c0, base, wb0;
    for (int i = 0; i < NR; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_rd[i] = 1'b0; r_wr[i] = 1'b0; r_bc[i] = '0;
    end
    txs_rdata = '0; txs_rdv = 1'b0; txs_wait = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_waitreq", 128'(req_waitrequest), 128'(2'b11));
    chk("rst_txs_cmd", 128'({txs_read, txs_write, txs_chipselect}), 128'(0));
    chk("rst_rdv", 128'(req_readdatavalid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 4-beat write: beats on 4 consecutive cycles, 1 cycle after request.
    exp_write(0, 64'h1000, 4, 6'd4);
    wr_cyc.delete();
    c0 = cyc;
    wr_burst(0, 64'h1000, 4, 6'd4);
    chk("w1_nbeats", 128'(wr_cyc.size()), 128'(4));
    chk("w1_first_cyc", 128'(wr_cyc[0] - c0), 128'(1));
    chk("w1_last_cyc", 128'(wr_cyc[3] - c0), 128'(4));

    // Burstcount 0 from req1 moves one beat and leaves last grantee = 1.
    exp_write(1, 64'h1800, 1, 6'd0);
    wr_burst(1, 64'h1800, 1, 6'd0);
    @(negedge clk);

    // Simultaneous writes alternate 0,1,0,1.
    for (int p = 0; p < 2; p++) begin
      exp_write(0, 64'h2000 + 64'(p), 2, 6'd2);
      exp_write(1, 64'h2800 + 64'(p), 2, 6'd2);
      fork
        wr_burst(0, 64'h2000 + 64'(p), 2, 6'd2);
        wr_burst(1, 64'h2800 + 64'(p), 2, 6'd2);
      join
    end
    chk("rr_drained", 128'(exp_wr.size()), 128'(0));

    // Reads 8 + 2 beats route in issue order.
    for (int k = 0; k < 8; k++) exp_rd.push_back(0);
    rd_burst(0, 64'h3000, 8);
    for (int k = 0; k < 2; k++) exp_rd.push_back(1);
    rd_burst(1, 64'h3800, 2);
    return_beats(10);
    chk("rd_all_routed", 128'(exp_rd.size()), 128'(0));

    // Fill the tracker, then req0 read is held while req1 write proceeds.
    base = rd_acc;
    for (int k = 0; k < RDD; k++) begin
      exp_rd.push_back(0); exp_rd.push_back(0);
      rd_burst(0, 64'h4000 + 64'(k * 32), 2);
    end
    chk("full_fill", 128'(rd_acc - base), 128'(RDD));
    exp_rd.push_back(0);
    exp_write(1, 64'h6000, 2, 6'd2);
    wb0 = wr_beats;
    fork
      rd_burst(0, 64'h7000, 1);
      wr_burst(1, 64'h6000, 2, 6'd2);
      begin
        repeat (8) @(negedge clk);
        #2;
        chk("full_hold_rd", 128'(rd_acc - base), 128'(RDD));
        chk("full_wait0", 128'(req_waitrequest[0]), 128'(1));
        chk("full_wr_beats", 128'(wr_beats - wb0), 128'(2));
        @(negedge clk);
        return_beats(2);
        repeat (4) @(negedge clk);
        chk("full_release", 128'(rd_acc - base), 128'(RDD + 1));
      end
    join
    return_beats(2 * (RDD - 1) + 1);
    chk("full_all_routed", 128'(exp_rd.size()), 128'(0));

    // Stall 5 cycles mid-burst; req1 competes but must wait for the burst end.
    exp_write(0, 64'h8000, 8, 6'd8);
    exp_write(1, 64'h9000, 1, 6'd1);
    wb0 = wr_beats;
    fork
      wr_burst(0, 64'h8000, 8, 6'd8);
      begin
        repeat (3) @(negedge clk);
        wr_burst(1, 64'h9000, 1, 6'd1);
      end
      begin
        int t = 0;
        while (wr_beats < wb0 + 2 && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("stall_reach", 128'(wr_beats >= wb0 + 2), 128'(1));
        txs_wait = 1'b1;
        repeat (5) begin
          #2;
          chk("stall_hold_wr", 128'(txs_write), 128'(1));
          chk("stall_waitreq", 128'(req_waitrequest), 128'(2'b11));
          @(negedge clk);
        end
        txs_wait = 1'b0;
      end
    join
    chk("stall_beats", 128'(wr_beats - wb0), 128'(9));
    chk("stall_drained", 128'(exp_wr.size()), 128'(0));
    chk("no_err_yet", 128'(err), 128'(0));

    // Orphan read data sets sticky err_o until reset.
    @(negedge clk);
    return_beats(1);
    #2 chk("err_set", 128'(err), 128'(1));
    repeat (3) @(negedge clk);
    #2 chk("err_sticky", 128'(err), 128'(1));
    rst_n = 1'b0;
    #1 chk("err_cleared", 128'(err), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2 chk("err_after_rst", 128'(err), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcie_txs_arbiter.md
# pcie_txs_arbiter

Shares the PCIe hard IP's single 128-bit Avalon-MM TXS slave port between NUM_REQ application masters (DMA engines, doorbell writer). Grants at burst granularity with round-robin fairness. Tracks outstanding reads in issue order and routes each returning read beat to the requester that issued it. Sits in the coreclkout_hip domain between the application masters and the hard IP's txs_* port.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- RD_DEPTH, 8: outstanding read bursts tracked, power of two, 2..32.
- coreclkout_hip  in  1  sole clock.
- app_nreset_status  in  1  reset; asynchronous, active-low.
- req_address_i  in  64*NUM_REQ  per-requester byte address; slice i is [64*i+:64].
- req_byteenable_i  in  16*NUM_REQ  per-requester byte enables.
- req_writedata_i  in  128*NUM_REQ  per-requester write data.
- req_read_i / req_write_i  in  NUM_REQ  per-requester command strobes.
- req_burstcount_i  in  6*NUM_REQ  beats per burst, 1..32.
- req_waitrequest_o  out  NUM_REQ  per-requester stall.
- req_readdata_o  out  128  broadcast read data.
- req_readdatavalid_o  out  NUM_REQ  one-hot read-data strobe.
- txs_address_i, txs_byteenable_i, txs_writedata_i, txs_read_i, txs_write_i, txs_burstcount_i, txs_chipselect_i  out  64/16/128/1/1/6/1  to the hard IP TXS port.
- txs_readdata_o, txs_readdatavalid_o, txs_waitrequest_o  in  128/1/1  from the hard IP.
- err_o  out  1  sticky: readdatavalid arrived with the tracker empty.

## Operation
- FSM states:
  - ARB: picks the next requester round-robin, starting after the last grantee. A requester is eligible when it asserts write, or asserts read while the tracker is not full. Goes to XFER with grant registered; stays in ARB if no requester is eligible.
  - XFER: the granted requester's command is muxed to txs_*; chipselect = read|write.
    - Read accepted (txs_read && !txs_waitrequest): push {id, burstcount} into the tracker; go to ARB.
    - Write beat accepted: increment the beat counter. Burstcount is latched on the first beat. When the counter reaches burstcount-1, go to ARB.
- req_waitrequest_o[i] = !(state==XFER && grant==i && !txs_waitrequest_o). All non-granted requesters see waitrequest high.
- Burstcount 0 is treated as 1.
- Tracker: in-order FIFO. Each txs_readdatavalid_o beat is routed to the head entry's id and increments the response counter. The head entry pops on its last beat. Push and pop in the same cycle are allowed; a push into a full tracker cannot occur, because ARB blocks it.
- readdatavalid with the tracker empty: err_o sets and the beat is dropped.
- Reset mid-burst or with reads outstanding: all state clears. Late responses therefore raise err_o; software must quiesce before reset.

## Timing
- Reset values: state ARB, last grantee NUM_REQ-1, txs_read/txs_write/txs_chipselect 0, req_waitrequest_o all 1, req_readdatavalid_o 0, err_o 0, tracker empty.
- Request latency: request seen in ARB at cycle N, txs command valid at N+1, earliest acceptance at N+1. Minimum gap between different grants is 1 idle ARB cycle.
- Read data is combinational pass-through: req_readdata_o = txs_readdata_o, with the valid strobe in the same cycle (zero latency).
- A write burst is never interleaved; the grant holds until its last beat, regardless of other requests.

## Structure
- Package pcie_txs_pkg holds:
  - constants TXS_ADDR_W=64, TXS_DATA_W=128, TXS_BE_W=16, TXS_BURST_W=6;
  - the FSM state enum;
  - the tracker entry typedef {id, burstcount}.
- Sub-module pcie_txs_rd_tracker: FIFO, response beat counter, and full/empty flags.

## Test plan
- Single requester, 4-beat write to 0x1000, txs_waitrequest low: txs_write is seen on 4 consecutive cycles starting 1 cycle after request, with burstcount=4.
- Both requesters request writes at once, with last grantee = 1: req0's 2-beat burst completes first, then req1's burst. Repeated simultaneous requests alternate 0,1,0,1.
- Req0 issues 8-beat read, then req1 issues 2-beat read; 10 readdatavalid beats return: the first 8 go to req_readdatavalid_o[0] and the last 2 to req_readdatavalid_o[1].
- Tracker filled with RD_DEPTH reads, req0 then asserts read and req1 asserts write: req1 is granted and req0 is held until the first burst fully returns.
- txs_waitrequest high for 5 cycles mid-write-burst: the grant holds, no beat is lost, and the beat count is still exact.
- txs_readdatavalid with the tracker empty: err_o goes to 1 and stays 1 until app_nreset_status is low.
